// File: rtl/gather4_8_pkg.sv
// -----------------------------------------------------------------------------
// gather4_pkg
//   Shared types and constants for the gather4_8 stream-to-lane packer.
//   - LANES          : number of output lanes (a, b, c, d)
//   - DEFAULT_WIDTH  : default lane/data width
//   - DEFAULT_CNT_W  : default width of the emitted-group counter
//   - lane_idx_t     : index of the next lane to fill
//   - state_t        : FILL (accepting values) / FULL (presenting a group)
//   - fill_count()   : number of filled lanes once lane 'idx' has been written
// -----------------------------------------------------------------------------
package gather4_pkg;

  localparam int LANES         = 4;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 16;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Lane count is idx+1 and must reach 4, so it needs one more bit than idx.
  function automatic logic [2:0] fill_count(input lane_idx_t idx);
    return {1'b0, idx} + 3'd1;
  endfunction

endpackage

// File: rtl/gather4_8_if.sv
// -----------------------------------------------------------------------------
// gather4_8_if
//   Bundles the input stream handshake and the packed output group of
//   gather4_8.
//   Input stream : in_data, in_valid, in_last (to block), in_ready (from block)
//   Output group : a, b, c, d, out_valid, out_count, group_count (from block),
//                  out_ready (to block)
//   Modports:
//     slave  - the gather4_8 block itself
//     master - the environment: upstream source plus downstream consumer
// -----------------------------------------------------------------------------
interface gather4_8_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_count;
  logic [CNT_W-1:0] group_count;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, a, b, c, d, out_valid, out_count, group_count
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, a, b, c, d, out_valid, out_count, group_count
  );

endinterface

// File: rtl/gather4_8.sv
// -----------------------------------------------------------------------------
// gather4_8
//   Packs a serial stream of WIDTH-bit values into four lanes (a, b, c, d) and
//   presents them as one stable, valid-qualified group for the adder tree.
//   in_last closes a partial group early; unfilled lanes read 0.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - gather4_8_if.slave:
//                in_data/in_valid/in_last/in_ready   input stream handshake
//                a/b/c/d                             packed lanes
//                out_valid/out_ready                 group handshake
//                out_count                           filled lanes (0 when idle)
//                group_count                         groups consumed, wraps
//
//   Timing: one group costs one accept per value plus one drain cycle, since
//   in_ready and out_valid decode only from the state register.
// -----------------------------------------------------------------------------
module gather4_8
  import gather4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  gather4_8_if.slave bus
);

  state_t           state_q;
  lane_idx_t        idx_q;
  logic [WIDTH-1:0] lane_q [LANES];
  logic [2:0]       out_count_q;
  logic [CNT_W-1:0] group_count_q;

  // NOTE: every register, including the small lane array, is reset so that
  // a reset mid-group or while FULL leaves no trace of the discarded group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      idx_q         <= '0;
      out_count_q   <= '0;
      group_count_q <= '0;
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of the state, index and lanes.
      unique case (state_q)
        FILL: begin
          if (bus.in_valid) begin
            lane_q[idx_q] <= bus.in_data;
            if (idx_q == lane_idx_t'(LANES - 1) || bus.in_last) begin
              state_q     <= FULL;
              out_count_q <= fill_count(idx_q);
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end

        FULL: begin
          // Lanes hold until the consumer takes them; in_valid is ignored here.
          if (bus.out_ready) begin
            // Clearing at drain is what zero-pads a short next group.
            for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
            idx_q         <= '0;
            out_count_q   <= '0;
            group_count_q <= group_count_q + 1'b1;
            state_q       <= FILL;
          end
        end

        default: state_q <= FILL;
      endcase
    end
  end

  // Handshake outputs decode from the state register only, so there is no
  // combinational path from out_ready to in_ready or in_valid to out_valid.
  assign bus.in_ready    = (state_q == FILL);
  assign bus.out_valid   = (state_q == FULL);

  assign bus.a           = lane_q[0];
  assign bus.b           = lane_q[1];
  assign bus.c           = lane_q[2];
  assign bus.d           = lane_q[3];
  assign bus.out_count   = out_count_q;
  assign bus.group_count = group_count_q;

endmodule

// File: tb/tb_gather4_8.sv
// -----------------------------------------------------------------------------
// tb_gather4_8
//   Directed self-checking bench for gather4_8. A small lane model predicts
//   each group as values are accepted and pushes it to a scoreboard; a monitor
//   pops and compares whenever the DUT hands a group downstream. The counter
//   width is reduced so the wrap case fits in a short run.
// -----------------------------------------------------------------------------
module tb_gather4_8;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [2:0]       cnt;
  } grp_t;

  logic clk;
  logic rst_n;

  gather4_8_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  gather4_8 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  grp_t       sb[$];
  logic [7:0] sum_log[$];

  logic [WIDTH-1:0] m_lane [4];
  int               m_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_lane[i] = '0;
    m_idx = 0;
  endtask

  // Present one value and wait (bounded) until it is accepted. 'waits' counts
  // the cycles spent with in_ready low.
  task automatic send(input logic [WIDTH-1:0] v, input logic last, output int waits);
    bit   done;
    logic rdy;
    grp_t g;
    done  = 1'b0;
    waits = 0;
    bus.in_data  = v;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy && rst_n) done = 1'b1;
      else waits++;
    end
    check("accept_in_time", 32'(done), 32'd1);
    if (done) begin
      m_lane[m_idx] = v;
      if (m_idx == 3 || last) begin
        g.a = m_lane[0]; g.b = m_lane[1]; g.c = m_lane[2]; g.d = m_lane[3];
        g.cnt = 3'(m_idx + 1);
        sb.push_back(g);
        model_clear();
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic check_lanes(input string tag, input logic [WIDTH-1:0] ea,
                             input logic [WIDTH-1:0] eb, input logic [WIDTH-1:0] ec,
                             input logic [WIDTH-1:0] ed, input logic [2:0] ecnt);
    check({tag, "_a"}, 32'(bus.a), 32'(ea));
    check({tag, "_b"}, 32'(bus.b), 32'(eb));
    check({tag, "_c"}, 32'(bus.c), 32'(ec));
    check({tag, "_d"}, 32'(bus.d), 32'(ed));
    check({tag, "_count"}, 32'(bus.out_count), 32'(ecnt));
  endtask

  task automatic check_sum(input string tag, input logic [7:0] exp);
    check({tag, "_logged"}, 32'(sum_log.size() > 0), 32'd1);
    if (sum_log.size() > 0) check(tag, 32'(sum_log.pop_front()), 32'(exp));
  endtask

  // Monitor: a group transfers on the next rising edge when both handshake
  // signals are high at the falling edge.
  always @(negedge clk) begin
    grp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("grp_a", 32'(bus.a), 32'(e.a));
        check("grp_b", 32'(bus.b), 32'(e.b));
        check("grp_c", 32'(bus.c), 32'(e.c));
        check("grp_d", 32'(bus.d), 32'(e.d));
        check("grp_count", 32'(bus.out_count), 32'(e.cnt));
      end
      sum_log.push_back(8'(bus.a + bus.b + bus.c + bus.d));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    model_clear();
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    #1;
    check_lanes("rst", 8'd0, 8'd0, 8'd0, 8'd0, 3'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_group_count", 32'(bus.group_count), 32'd0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full group 4, 5, 11, 9.
    send(8'd4, 1'b0, w);
    send(8'd5, 1'b0, w);
    send(8'd11, 1'b0, w);
    send(8'd9, 1'b0, w);
    bus.in_valid = 1'b0;
    check("g1_out_valid", 32'(bus.out_valid), 32'd1);
    check("g1_in_ready", 32'(bus.in_ready), 32'd0);
    check_lanes("g1", 8'd4, 8'd5, 8'd11, 8'd9, 3'd4);
    @(posedge clk); #1;
    check("g1_out_valid_one_cycle", 32'(bus.out_valid), 32'd0);
    check("g1_group_count", 32'(bus.group_count), 32'd1);
    check_lanes("g1_cleared", 8'd0, 8'd0, 8'd0, 8'd0, 3'd0);
    check_sum("g1_sum", 8'd29);

    // Two groups back-to-back; the first value of the second group waits one
    // cycle for the drain bubble.
    send(8'd15, 1'b0, w);
    send(8'd3, 1'b0, w);
    send(8'd200, 1'b0, w);
    send(8'd7, 1'b0, w);
    send(8'd200, 1'b0, w);
    check("b2b_bubble_cycles", 32'(w), 32'd1);
    send(8'd100, 1'b0, w);
    send(8'd50, 1'b0, w);
    send(8'd10, 1'b0, w);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_group_count", 32'(bus.group_count), 32'd3);
    check_sum("b2b_sum0", 8'd225);
    check_sum("b2b_sum1", 8'd104);

    // Short groups closed by in_last.
    send(8'd7, 1'b0, w);
    send(8'd9, 1'b1, w);
    bus.in_valid = 1'b0;
    check_lanes("last2", 8'd7, 8'd9, 8'd0, 8'd0, 3'd2);
    @(posedge clk); #1;
    check_sum("last2_sum", 8'd16);
    send(8'd42, 1'b1, w);
    bus.in_valid = 1'b0;
    check_lanes("last1", 8'd42, 8'd0, 8'd0, 8'd0, 3'd1);
    @(posedge clk); #1;
    check_sum("last1_sum", 8'd42);

    // in_last on the fourth value behaves like a plain fourth value.
    send(8'd1, 1'b0, w);
    send(8'd2, 1'b0, w);
    send(8'd3, 1'b0, w);
    send(8'd250, 1'b1, w);
    bus.in_valid = 1'b0;
    check_lanes("last4", 8'd1, 8'd2, 8'd3, 8'd250, 3'd4);
    @(posedge clk); #1;
    check_sum("last4_sum", 8'd0);

    // Backpressure: hold out_ready low while a new value waits.
    bus.out_ready = 1'b0;
    send(8'd10, 1'b0, w);
    send(8'd20, 1'b0, w);
    send(8'd30, 1'b0, w);
    send(8'd40, 1'b0, w);
    bus.in_data  = 8'd77;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check_lanes("hold", 8'd10, 8'd20, 8'd30, 8'd40, 3'd4);
    end
    @(posedge clk); #1;
    check("hold_group_count", 32'(bus.group_count), 32'd6);
    bus.out_ready = 1'b1;
    send(8'd77, 1'b0, w);
    check("hold_drain_wait", 32'(w), 32'd1);
    check_sum("hold_sum", 8'd100);
    send(8'd1, 1'b0, w);
    send(8'd2, 1'b0, w);
    send(8'd3, 1'b0, w);
    bus.in_valid = 1'b0;
    check_lanes("held_value_lane_a", 8'd77, 8'd1, 8'd2, 8'd3, 3'd4);
    @(posedge clk); #1;
    check_sum("held_sum", 8'd83);

    // Asynchronous reset mid-group discards the partial group and ignores
    // transfers presented while reset is low.
    send(8'd5, 1'b0, w);
    send(8'd6, 1'b0, w);
    #3;
    rst_n        = 1'b0;
    bus.in_data  = 8'd99;
    bus.in_valid = 1'b1;
    model_clear();
    #1;
    check_lanes("arst", 8'd0, 8'd0, 8'd0, 8'd0, 3'd0);
    check("arst_group_count", 32'(bus.group_count), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    #9;
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    check("arst_ignored_a", 32'(bus.a), 32'd0);
    @(posedge clk); #1;
    send(8'd1, 1'b0, w);
    send(8'd2, 1'b0, w);
    send(8'd3, 1'b0, w);
    send(8'd4, 1'b0, w);
    bus.in_valid = 1'b0;
    check_lanes("post_rst", 8'd1, 8'd2, 8'd3, 8'd4, 3'd4);
    @(posedge clk); #1;
    check("post_rst_group_count", 32'(bus.group_count), 32'd1);
    check_sum("post_rst_sum", 8'd10);

    // Counter wrap with single-value groups.
    for (int i = 0; i < (1 << CNT_W) - 2; i++) send(8'($urandom_range(0, 255)), 1'b1, w);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("gc_max", 32'(bus.group_count), 32'((1 << CNT_W) - 1));
    send(8'($urandom_range(0, 255)), 1'b1, w);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("gc_wrap", 32'(bus.group_count), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gather4_8.md
Name: gather4_8

Overview:
Upstream feeder for the 4-input, 8-bit adder tree. Accepts a serial stream of 8-bit values over a valid/ready handshake and packs four consecutive values into lanes a, b, c and d. Presents the group as one stable, valid-qualified bundle. An early-terminate input (in_last) closes a partial group, with unfilled lanes zero-padded so the downstream sum stays correct.

Parameters:
WIDTH, 8, lane/data width in bits; a, b, c, d connect directly to the adder tree inputs.
CNT_W, 16, width of the emitted-group counter.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_data  input  WIDTH  stream value
in_valid  input  1  in_data valid
in_last  input  1  closes the current group after this value; qualified by in_valid
in_ready  output  1  block can accept a value
a  output  WIDTH  lane 0 (first value of group)
b  output  WIDTH  lane 1
c  output  WIDTH  lane 2
d  output  WIDTH  lane 3
out_valid  output  1  lanes hold a complete group
out_ready  input  1  downstream consumes the group
out_count  output  3  number of filled lanes, 1..4; 0 when out_valid=0
group_count  output  CNT_W  number of groups consumed, wraps

Behaviour:
- State machine, two states:
  - FILL: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1.
- in_ready and out_valid decode from the state register only. There is no combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Reset (rst_n low, asynchronous):
  - state=FILL, lane index idx=0.
  - a=b=c=d=0, out_count=0, group_count=0.
  - Transfers presented while rst_n is low are ignored.
  - Reset asserted mid-group or while FULL discards the partial or pending group; no output is produced for it.
- FILL, on accept (in_valid && in_ready):
  - Lane[idx] <= in_data.
  - If idx==3 or in_last=1: go to FULL and set out_count=idx+1.
  - Otherwise idx <= idx+1.
- FULL:
  - a, b, c, d and out_count stay stable until the handshake.
  - in_valid is ignored; no value is accepted.
- FULL, on out_valid && out_ready:
  - Lanes cleared to 0, idx=0, out_count=0.
  - group_count <= group_count+1, with modulo-2^CNT_W wrap.
  - Return to FILL.
- Zero padding: lanes are cleared at each group start, so unfilled lanes read 0 when out_valid=1.
- Latency: the value that completes a group (4th value, or one with in_last) is accepted at edge N; out_valid is high after edge N.
- Throughput: minimum one bubble per group. A full group takes 4 accept cycles plus 1 drain cycle, i.e. 5 cycles per 4 values best case.
- in_last with idx==3 behaves the same as a plain 4th value.
- Outputs are registered; no arithmetic is done here. Sum width and overflow belong to the adder tree (8-bit, modulo 256).

Decomposition:
- Package gather4_pkg holds: LANES=4, default WIDTH=8, typedef lane_idx_t (2-bit), and enum state_t {FILL, FULL}.
- Single module; no internal sub-module.
- System pairing: gather4_8 drives adder_tree4_8 (a, b, c, d) directly. The sum is valid when out_valid=1.

Test Plan:
- Stream 4, 5, 11, 9 with out_ready=1 -> after the 4th accept: a=4, b=5, c=11, d=9, out_count=4, out_valid=1 for exactly 1 cycle; tree sum=29; group_count=1.
- Stream 15, 3, 200, 7 then 200, 100, 50, 10 back-to-back -> groups emitted with sums 225 and 104 (360 mod 256); in_ready low for 1 cycle per group; group_count=2.
- Stream 7, then 9 with in_last=1 -> a=7, b=9, c=0, d=0, out_count=2, sum=16. Single value 42 with in_last=1 -> a=42, b=c=d=0, out_count=1.
- Complete a group with out_ready held low for 3 cycles while in_valid stays high -> lanes and out_count stable, in_ready=0, no value consumed. The held stream value becomes lane a of the next group after drain.
- Accept 2 values, then pulse rst_n low for 1 cycle (asynchronous, mid-cycle) -> all outputs 0 immediately. A following 4-value group is emitted intact.
- Send 65536 single-value groups (in_last=1, out_ready=1) -> group_count reaches 65535, then wraps to 0.
